// File: rtl/datapath_scsi_packer_if.sv
// Bus bundle between the SCSI/FIFO lane packer and its surroundings.
// master = DMA sequencer + SCSI controller + FIFO side, slave = packer.
interface datapath_scsi_packer_if #(
  parameter int FIFO_W = 32,
  parameter int SCSI_W = 8,
  parameter int CNT_W  = 16
);
  localparam int LANES = FIFO_W / SCSI_W;
  localparam int PTR_W = (LANES > 1) ? $clog2(LANES) : 1;

  logic              start;
  logic              dir;
  logic [PTR_W-1:0]  bo;
  logic              flush;
  logic [SCSI_W-1:0] scsi_din;
  logic              scsi_din_vld;
  logic              scsi_din_rdy;
  logic [SCSI_W-1:0] scsi_dout;
  logic              scsi_dout_vld;
  logic              scsi_dout_rdy;
  logic [FIFO_W-1:0] fifo_din;
  logic              fifo_din_vld;
  logic              fifo_din_rdy;
  logic [FIFO_W-1:0] fifo_dout;
  logic [LANES-1:0]  fifo_be;
  logic              fifo_dout_vld;
  logic              fifo_dout_rdy;
  logic [PTR_W-1:0]  lane_ptr;
  logic              busy;
  logic [CNT_W-1:0]  words_out;

  modport master (
    output start, dir, bo, flush,
    output scsi_din, scsi_din_vld, scsi_dout_rdy,
    output fifo_din, fifo_din_vld, fifo_dout_rdy,
    input  scsi_din_rdy, scsi_dout, scsi_dout_vld,
    input  fifo_din_rdy, fifo_dout, fifo_be, fifo_dout_vld,
    input  lane_ptr, busy, words_out
  );

  modport slave (
    input  start, dir, bo, flush,
    input  scsi_din, scsi_din_vld, scsi_dout_rdy,
    input  fifo_din, fifo_din_vld, fifo_dout_rdy,
    output scsi_din_rdy, scsi_dout, scsi_dout_vld,
    output fifo_din_rdy, fifo_dout, fifo_be, fifo_dout_vld,
    output lane_ptr, busy, words_out
  );
endinterface

// File: rtl/datapath_scsi_packer.sv
// SCSI<->FIFO lane packer. S2F packs SCSI beats into FIFO words with lane
// enables; F2S pops FIFO words and serialises them lane by lane. Both start
// at an arbitrary lane. All ready/valid outputs are decoded from state only.
module datapath_scsi_packer #(
  parameter int FIFO_W = 32,
  parameter int SCSI_W = 8,
  parameter int CNT_W  = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  datapath_scsi_packer_if.slave bus
);
  localparam int LANES = FIFO_W / SCSI_W;
  localparam int PTR_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [2:0] {S_IDLE, S_PACK, S_PUSH, S_LOAD, S_SEND} state_t;

  state_t            state, state_nxt;
  logic [FIFO_W-1:0] word;
  logic [LANES-1:0]  be;
  logic [PTR_W-1:0]  ptr;
  logic [CNT_W-1:0]  cnt;
  logic              done;   // transfer ends after the pending push
  logic [SCSI_W-1:0] lane_q;

  logic beat_in, push, pop, sent, last;

  // Flush wins over a pop/accept in LOAD/SEND: those handshakes do not count.
  assign beat_in = (state == S_PACK) && bus.scsi_din_vld;
  assign push    = (state == S_PUSH) && bus.fifo_dout_rdy;
  assign pop     = (state == S_LOAD) && bus.fifo_din_vld && !bus.flush;
  assign sent    = (state == S_SEND) && bus.scsi_dout_rdy && !bus.flush;
  assign last    = (ptr == PTR_W'(LANES - 1));

  // Select the lane addressed by the pointer (lane 0 is the MS lane).
  always_comb begin
    lane_q = '0;
    for (int k = 0; k < LANES; k++)
      if (ptr == PTR_W'(k)) lane_q = word[FIFO_W-1-k*SCSI_W -: SCSI_W];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and state-derived handshake outputs.
  always_comb begin
    state_nxt         = state;
    bus.scsi_din_rdy  = 1'b0;
    bus.scsi_dout_vld = 1'b0;
    bus.fifo_din_rdy  = 1'b0;
    bus.fifo_dout_vld = 1'b0;
    bus.scsi_dout     = '0;
    bus.fifo_dout     = word;
    bus.fifo_be       = be;
    bus.lane_ptr      = ptr;
    bus.words_out     = cnt;
    bus.busy          = (state != S_IDLE);
    case (state)
      S_IDLE: if (bus.start) state_nxt = bus.dir ? S_PACK : S_LOAD;
      S_PACK: begin
        bus.scsi_din_rdy = 1'b1;
        if (beat_in) begin
          if (bus.flush || last) state_nxt = S_PUSH;
        end else if (bus.flush) begin
          state_nxt = (be != '0) ? S_PUSH : S_IDLE;
        end
      end
      S_PUSH: begin
        bus.fifo_dout_vld = 1'b1;
        if (push) state_nxt = (done || bus.flush) ? S_IDLE : S_PACK;
      end
      S_LOAD: begin
        bus.fifo_din_rdy = 1'b1;
        if (bus.flush) state_nxt = S_IDLE;
        else if (pop)  state_nxt = S_SEND;
      end
      S_SEND: begin
        bus.scsi_dout_vld = 1'b1;
        bus.scsi_dout     = lane_q;
        if (bus.flush)        state_nxt = S_IDLE;
        else if (sent && last) state_nxt = S_LOAD;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Word/lane-enable/pointer/counter datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word <= '0;
      be   <= '0;
      ptr  <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (bus.start) begin
          ptr  <= bus.bo;
          word <= '0;
          be   <= '0;
          cnt  <= '0;
          done <= 1'b0;
        end
        S_PACK: begin
          if (beat_in) begin
            for (int k = 0; k < LANES; k++)
              if (ptr == PTR_W'(k)) begin
                word[FIFO_W-1-k*SCSI_W -: SCSI_W] <= bus.scsi_din;
                be[k] <= 1'b1;
              end
            if (!bus.flush && !last) ptr <= ptr + PTR_W'(1);
          end
          if (bus.flush) done <= 1'b1;
        end
        S_PUSH: begin
          if (bus.flush) done <= 1'b1;
          if (push) begin
            cnt  <= cnt + CNT_W'(1);
            word <= '0;
            be   <= '0;
            ptr  <= '0;
            done <= 1'b0;
          end
        end
        S_LOAD: if (pop) begin
          word <= bus.fifo_din;
          cnt  <= cnt + CNT_W'(1);
        end
        S_SEND: if (sent) ptr <= last ? '0 : ptr + PTR_W'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_datapath_scsi_packer.sv
// Randomised bench for datapath_scsi_packer with a transaction-level model:
// expected pushes/beats are derived from absolute stream positions.
module tb_datapath_scsi_packer;
  localparam int FW = 32, SW = 8, CW = 16, LN = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  datapath_scsi_packer_if #(.FIFO_W(FW), .SCSI_W(SW), .CNT_W(CW)) bus ();
  datapath_scsi_packer #(.FIFO_W(FW), .SCSI_W(SW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  datapath_scsi_packer_if #(.FIFO_W(32), .SCSI_W(16), .CNT_W(CW)) bus16 ();
  datapath_scsi_packer #(.FIFO_W(32), .SCSI_W(16), .CNT_W(CW)) dut16 (
    .clk(clk), .rst_n(rst_n), .bus(bus16));

  int checks = 0, passes = 0;
  int fr_mode = 0, sr_mode = 0;   // 0 random, 1 low, 2 high
  logic [31:0] exp_w[$];
  logic [3:0]  exp_be[$];
  logic [7:0]  exp_b[$];
  int cnt_m = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Downstream ready generators.
  initial begin
    bus.fifo_dout_rdy = 1'b0;
    bus.scsi_dout_rdy = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.fifo_dout_rdy = (fr_mode == 2) || (fr_mode == 0 && $urandom_range(0, 3) != 0);
      bus.scsi_dout_rdy = (sr_mode == 2) || (sr_mode == 0 && $urandom_range(0, 3) != 0);
    end
  end

  // Compare process: every cycle, checks handshakes against the model queues.
  logic pv_f = 0, pa_f = 0, pv_s = 0, pa_s = 0, pfl = 0;
  logic [31:0] pw = 0;
  logic [3:0]  pbe = 0;
  logic [7:0]  pb = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      pv_f <= 0; pv_s <= 0;
    end else begin
      if (bus.start && !bus.busy) cnt_m <= 0;
      chk("idle_quiet", !bus.busy && (bus.scsi_din_rdy | bus.fifo_din_rdy |
          bus.fifo_dout_vld | bus.scsi_dout_vld), 0);
      chk("one_handshake", $countones({bus.scsi_din_rdy, bus.fifo_din_rdy,
          bus.fifo_dout_vld, bus.scsi_dout_vld}) > 1, 0);
      if (pv_f && !pa_f) chk("push_hold", {bus.fifo_dout_vld, bus.fifo_be, bus.fifo_dout}, {1'b1, pbe, pw});
      if (pv_s && !pa_s && !pfl) chk("beat_hold", {bus.scsi_dout_vld, bus.scsi_dout}, {1'b1, pb});
      if (bus.busy) chk("words_out", bus.words_out, 16'(cnt_m));
      if (bus.fifo_dout_vld && bus.fifo_dout_rdy) begin
        cnt_m <= cnt_m + 1;
        if (exp_w.size() == 0) chk("unexpected_push", 1, 0);
        else begin
          chk("push_word", bus.fifo_dout, exp_w.pop_front());
          chk("push_be", bus.fifo_be, exp_be.pop_front());
        end
      end
      if (bus.scsi_dout_vld && bus.scsi_dout_rdy && !bus.flush) begin
        if (exp_b.size() == 0) chk("unexpected_beat", 1, 0);
        else chk("beat", bus.scsi_dout, exp_b.pop_front());
      end
      if (bus.fifo_din_vld && bus.fifo_din_rdy && !bus.flush) cnt_m <= cnt_m + 1;
      pv_f <= bus.fifo_dout_vld; pa_f <= bus.fifo_dout_rdy;
      pv_s <= bus.scsi_dout_vld; pa_s <= bus.scsi_dout_rdy;
      pw <= bus.fifo_dout; pbe <= bus.fifo_be; pb <= bus.scsi_dout; pfl <= bus.flush;
    end
  end

  // Model: beat i lands at stream position bo+i -> word (p/LN), lane (p%LN).
  task automatic model_s2f(input int bo, input logic [7:0] beats[$], output int nw);
    logic [31:0] mw[$];
    logic [3:0]  mb[$];
    logic [31:0] t;
    logic [3:0]  e;
    int p;
    nw = (bo + beats.size() - 1) / LN + 1;
    for (int i = 0; i < nw; i++) begin mw.push_back(0); mb.push_back(0); end
    for (int i = 0; i < beats.size(); i++) begin
      p = bo + i;
      t = mw[p / LN]; t[31 - (p % LN) * 8 -: 8] = beats[i]; mw[p / LN] = t;
      e = mb[p / LN]; e[p % LN] = 1'b1; mb[p / LN] = e;
    end
    for (int i = 0; i < nw; i++) begin exp_w.push_back(mw[i]); exp_be.push_back(mb[i]); end
  endtask

  // Model: output beats are stream positions bo .. words*LN-1.
  task automatic model_f2s(input int bo, input logic [31:0] words[$]);
    logic [31:0] t;
    for (int p = bo; p < words.size() * LN; p++) begin
      t = words[p / LN];
      exp_b.push_back(t[31 - (p % LN) * 8 -: 8]);
    end
  endtask

  task automatic do_start(input bit dir, input int bo);
    int g = 0;
    while (bus.busy && g < 300) begin tick(); g++; end
    if (g >= 300) chk("idle_timeout", 0, 1);
    bus.start = 1'b1; bus.dir = dir; bus.bo = 2'(bo);
    tick();
    bus.start = 1'b0; bus.bo = 2'($urandom);
  endtask

  task automatic send_beat(input logic [7:0] b, input bit with_flush);
    int g = 0;
    repeat ($urandom_range(0, 2)) tick();
    bus.scsi_din = b; bus.scsi_din_vld = 1'b1;
    while (!bus.scsi_din_rdy && g < 100) begin tick(); g++; end
    if (g >= 100) chk("beat_accept_timeout", 0, 1);
    bus.flush = with_flush;
    tick();
    bus.scsi_din_vld = 1'b0; bus.flush = 1'b0; bus.scsi_din = 8'($urandom);
  endtask

  task automatic finish_s2f(input int nw, input bit do_flush);
    int g = 0;
    if (do_flush) begin bus.flush = 1'b1; tick(); bus.flush = 1'b0; end
    while (bus.busy && g < 300) begin tick(); g++; end
    if (g >= 300) chk("s2f_end_timeout", 0, 1);
    chk("s2f_words_out", bus.words_out, 16'(nw));
    chk("s2f_drained", exp_w.size(), 0);
  endtask

  task automatic s2f(input int bo, input logic [7:0] beats[$], input bit fwl);
    int nw;
    model_s2f(bo, beats, nw);
    do_start(1'b1, bo);
    for (int i = 0; i < beats.size(); i++) send_beat(beats[i], fwl && (i == beats.size() - 1));
    finish_s2f(nw, !fwl);
  endtask

  task automatic feed_word(input logic [31:0] w);
    int g = 0;
    repeat ($urandom_range(0, 2)) tick();
    bus.fifo_din = w; bus.fifo_din_vld = 1'b1;
    while (!bus.fifo_din_rdy && g < 300) begin tick(); g++; end
    if (g >= 300) chk("pop_timeout", 0, 1);
    tick();
    bus.fifo_din_vld = 1'b0; bus.fifo_din = $urandom;
  endtask

  task automatic run_f2s(input int bo, input logic [31:0] words[$]);
    int g = 0;
    do_start(1'b0, bo);
    foreach (words[i]) feed_word(words[i]);
    while (!(exp_b.size() == 0 && bus.fifo_din_rdy) && g < 300) begin tick(); g++; end
    if (g >= 300) chk("f2s_drain_timeout", 0, 1);
    bus.flush = 1'b1; tick(); bus.flush = 1'b0;
    chk("f2s_idle", bus.busy, 0);
    chk("f2s_words_out", bus.words_out, 16'(words.size()));
  endtask

  initial begin
    logic [7:0]  bq[$];
    logic [31:0] wq[$];
    int nw, g;
    bus.start = 0; bus.dir = 0; bus.bo = 0; bus.flush = 0;
    bus.scsi_din = 0; bus.scsi_din_vld = 0; bus.fifo_din = 0; bus.fifo_din_vld = 0;
    bus16.start = 0; bus16.dir = 0; bus16.bo = 0; bus16.flush = 0;
    bus16.scsi_din = 0; bus16.scsi_din_vld = 0; bus16.fifo_din = 0; bus16.fifo_din_vld = 0;
    bus16.scsi_dout_rdy = 0; bus16.fifo_dout_rdy = 0;

    // Reset state.
    #12;
    chk("rst_data", {bus.fifo_dout, bus.fifo_be, bus.scsi_dout}, 0);
    chk("rst_ctrl", {bus.scsi_din_rdy, bus.scsi_dout_vld, bus.fifo_din_rdy, bus.fifo_dout_vld,
                     bus.lane_ptr, bus.busy, bus.words_out}, 0);
    tick(); rst_n = 1'b1; tick();

    // FLUSH alone in IDLE does nothing.
    bus.flush = 1'b1; tick(); bus.flush = 1'b0;
    chk("idle_flush", bus.busy, 0);

    // S2F, BO=0: one full word, VLD the clock after the last beat.
    bq = '{8'h11, 8'h22, 8'h33, 8'h44};
    model_s2f(0, bq, nw);
    chk("pin_w0", exp_w[0], 32'h11223344);
    chk("pin_be0", exp_be[0], 4'b1111);
    do_start(1'b1, 0);
    foreach (bq[i]) send_beat(bq[i], 1'b0);
    chk("last_beat_latency", bus.fifo_dout_vld, 1);
    finish_s2f(nw, 1'b1);

    // S2F, BO=2: AA BB CC then FLUSH.
    bq = '{8'hAA, 8'hBB, 8'hCC};
    model_s2f(2, bq, nw);
    chk("pin_w1", {exp_w[0], exp_be[0]}, {32'h0000AABB, 4'b1100});
    chk("pin_w2", {exp_w[1], exp_be[1]}, {32'hCC000000, 4'b0001});
    exp_w.delete(); exp_be.delete();
    s2f(2, bq, 1'b0);

    // S2F with FIFO back-pressure for 5 clocks.
    fr_mode = 1;
    bq = '{8'h5A, 8'h6B, 8'h7C, 8'h8D};
    model_s2f(0, bq, nw);
    do_start(1'b1, 0);
    foreach (bq[i]) send_beat(bq[i], 1'b0);
    repeat (5) begin
      chk("bp_vld", bus.fifo_dout_vld, 1);
      chk("bp_din_rdy", bus.scsi_din_rdy, 0);
      tick();
    end
    fr_mode = 0;
    finish_s2f(nw, 1'b1);

    // F2S, BO=1: two words -> seven beats.
    wq = '{32'h01020304, 32'h05060708};
    model_f2s(1, wq);
    chk("pin_beats", {8'(exp_b.size()), exp_b[0], exp_b[6]}, {8'd7, 8'h02, 8'h08});
    run_f2s(1, wq);

    // F2S flush mid-word: remaining lanes discarded.
    exp_b.push_back(8'hA1); exp_b.push_back(8'hB2);
    do_start(1'b0, 0);
    feed_word(32'hA1B2C3D4);
    g = 0;
    while (exp_b.size() != 0 && g < 300) begin tick(); g++; end
    if (g >= 300) chk("partial_timeout", 0, 1);
    bus.flush = 1'b1; tick(); bus.flush = 1'b0;
    chk("partial_idle", bus.busy, 0);
    chk("partial_words", bus.words_out, 16'd1);

    // 16-bit beats: DEADBEEF -> DEAD, BEEF, then back to LOAD.
    bus16.start = 1'b1; bus16.dir = 1'b0; bus16.bo = 1'b0; tick(); bus16.start = 1'b0;
    bus16.fifo_din = 32'hDEADBEEF; bus16.fifo_din_vld = 1'b1;
    chk("w16_load", bus16.fifo_din_rdy, 1);
    tick(); bus16.fifo_din_vld = 1'b0; bus16.scsi_dout_rdy = 1'b1;
    chk("w16_beat0", {bus16.scsi_dout_vld, bus16.scsi_dout}, {1'b1, 16'hDEAD});
    tick();
    chk("w16_beat1", {bus16.scsi_dout_vld, bus16.scsi_dout}, {1'b1, 16'hBEEF});
    tick();
    chk("w16_reload", {bus16.fifo_din_rdy, bus16.scsi_dout_vld, bus16.words_out}, {1'b1, 1'b0, 16'd1});
    bus16.scsi_dout_rdy = 1'b0; bus16.flush = 1'b1; tick(); bus16.flush = 1'b0;
    chk("w16_idle", bus16.busy, 0);

    // Async reset mid-PACK with two lanes filled.
    do_start(1'b1, 0);
    send_beat(8'hE1, 1'b0);
    send_beat(8'hE2, 1'b0);
    #3 rst_n = 1'b0; #1;
    chk("mid_rst_data", {bus.fifo_dout, bus.fifo_be, bus.scsi_dout}, 0);
    chk("mid_rst_ctrl", {bus.scsi_din_rdy, bus.scsi_dout_vld, bus.fifo_din_rdy, bus.fifo_dout_vld,
                         bus.lane_ptr, bus.busy, bus.words_out}, 0);
    tick(); rst_n = 1'b1; tick();
    bq = '{8'h91, 8'h92, 8'h93, 8'h94};
    s2f(0, bq, 1'b0);

    // Random mix of transfers.
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        bq.delete();
        repeat ($urandom_range(1, 10)) bq.push_back(8'($urandom));
        s2f($urandom_range(0, 3), bq, 1'($urandom_range(0, 1)));
      end else begin
        int bo = $urandom_range(0, 3);
        wq.delete();
        repeat ($urandom_range(1, 3)) wq.push_back($urandom);
        model_f2s(bo, wq);
        run_f2s(bo, wq);
      end
    end

    chk("end_queues", {16'(exp_w.size()), 16'(exp_b.size())}, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
